// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes 32-bit words into instruction memory and holds the core in reset until the load succeeds
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_data/in_ready : byte stream from host link (valid/ready)
//   imem_we/imem_addr/imem_wdata : one-cycle word write, byte address word_idx*4
//   core_hold             : core reset request, released only after a good load
//   load_done, err        : sticky completion / frame error flags
//   words_loaded          : words written so far
//   Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte
module imem_loader #(
  parameter int NUM_INSTR      = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        err,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;
  localparam logic [31:0] MAX = 32'(NUM_INSTR);
  localparam logic [31:0] TO  = 32'(TIMEOUT_CYCLES);
  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [31:0] idle;
  logic        accept;
  logic        timed;
  logic        timeout;
  logic [15:0] cnt_full;
  logic [15:0] word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xsum;
`endif
  assign in_ready     = (state != DONE) && (state != ERR);
  assign accept       = in_valid & in_ready;
  assign words_loaded = word_idx;
  assign cnt_full     = {in_data, count[7:0]};
  assign word_next    = word_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign timed = (state == CNT_HI) || (state == DATA) || (state == CHK);
`else
  assign timed = (state == CNT_HI) || (state == DATA);
`endif
  // idle counts edges since the last accepted byte; hitting the limit on a byte-less edge aborts
  assign timeout = timed && !accept && (TO != 32'd0) && (idle == TO - 32'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CNT_LO;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      idle       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xsum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      idle    <= (accept || !timed) ? 32'd0 : idle + 32'd1;
      if (timeout) begin
        state <= ERR;
        err   <= 1'b1;
      end else if (accept) begin
        case (state)
          CNT_LO: begin
            count[7:0] <= in_data;
            state      <= CNT_HI;
          end
          CNT_HI: begin
            count    <= cnt_full;
            word_idx <= '0;
            byte_idx <= '0;
            if (cnt_full == 16'd0 || {16'd0, cnt_full} > MAX) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            // bytes arrive LSB first, so shift in from the top and take byte 3 straight from the bus
            asm_q    <= {in_data, asm_q[23:8]};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum     <= xsum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {in_data, asm_q};
              imem_addr  <= {14'b0, word_idx, 2'b00};
              word_idx   <= word_next;
              if (word_next == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state     <= DONE;
                core_hold <= 1'b0;
                load_done <= 1'b1;
`endif
              end
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CHK: begin
            if (in_data == xsum) begin
              state     <= DONE;
              core_hold <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with directed frames
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        err;
  logic [15:0] words_loaded;
  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  imem_loader #(.NUM_INSTR(1024), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .err(err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (imem_we) begin
      wr_cnt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr %h data %h, required no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          n_fail++;
          $display("FAIL write: got addr %h data %h, required addr %h data %h", imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic do_reset(input bit check);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    if (check) begin
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      chk("rst_flags", {29'd0, core_hold, load_done, err}, 32'b100);
      chk("rst_ready", 32'(in_ready), 32'd1);
    end
    rst = 1'b0;
  endtask
  task automatic stall(input int max_stall);
    repeat ($urandom_range(0, max_stall)) @(negedge clk);
  endtask
  task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input int max_stall);
    logic [31:0] w [3];
    logic [31:0] cur;
    logic [15:0] cnt;
    logic [7:0]  x;
    w = '{w0, w1, w2};
    cnt = 16'(n);
    x = 8'h00;
    for (int i = 0; i < n; i++) push(32'(i * 4), w[i]);
    send(cnt[7:0]);
    stall(max_stall);
    send(cnt[15:8]);
    for (int i = 0; i < n; i++) begin
      cur = w[i];
      for (int b = 0; b < 4; b++) begin
        stall(max_stall);
        x = x ^ cur[8*b +: 8];
        send(cur[8*b +: 8]);
      end
    end
    chk("last_we", 32'(imem_we), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x);
`endif
    @(negedge clk);
  endtask
  task automatic expect_err(input string name, input int wr0);
    repeat (2) @(negedge clk);
    chk({name, "_flags"}, {29'd0, core_hold, load_done, err}, 32'b101);
    chk({name, "_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_nowrite"}, 32'(wr_cnt - wr0), 32'd0);
  endtask
  initial begin
    int wr0;
    do_reset(1'b1);
    // two-word program, back-to-back bytes
    send_frame(2, 32'h00A00513, 32'h00100593, 32'h0, 0);
    repeat (3) send(8'h55);
    repeat (2) @(negedge clk);
    chk("f1_flags", {29'd0, core_hold, load_done, err}, 32'b010);
    chk("f1_words", 32'(words_loaded), 32'd2);
    chk("f1_ready", 32'(in_ready), 32'd0);
    chk("f1_drain", 32'(exp_q.size()), 32'd0);
    // count of zero
    do_reset(1'b0);
    wr0 = wr_cnt;
    send(8'h00);
    send(8'h00);
    expect_err("cnt0", wr0);
    // count one past the memory depth
    do_reset(1'b0);
    wr0 = wr_cnt;
    send(8'h01);
    send(8'h04);
    expect_err("cnt401", wr0);
    // count equal to the depth is legal
    do_reset(1'b0);
    send(8'h00);
    send(8'h04);
    chk("cnt400_err", 32'(err), 32'd0);
    chk("cnt400_ready", 32'(in_ready), 32'd1);
    // timeout after 16 idle cycles mid-word
    do_reset(1'b0);
    wr0 = wr_cnt;
    send(8'h01);
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    repeat (15) @(negedge clk);
    chk("to_15_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("to_16_err", 32'(err), 32'd1);
    expect_err("to", wr0);
    // reset mid-load after the first word was already written
    do_reset(1'b0);
    push(32'h0, 32'hDEADBEEF);
    send(8'h02);
    send(8'h00);
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    send(8'h01);
    do_reset(1'b1);
    send_frame(1, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    chk("rl_flags", {29'd0, core_hold, load_done, err}, 32'b010);
    chk("rl_words", 32'(words_loaded), 32'd1);
    // three words with random stalls below the timeout
    do_reset(1'b0);
    send_frame(3, 32'h11223344, 32'hCAFEF00D, 32'h0000006F, 3);
    chk("st_flags", {29'd0, core_hold, load_done, err}, 32'b010);
    chk("st_words", 32'(words_loaded), 32'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    // good trailing checksum
    do_reset(1'b0);
    push(32'h0, 32'h44332211);
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h44);
    @(negedge clk);
    chk("cs_ok_flags", {29'd0, core_hold, load_done, err}, 32'b010);
    // bad trailing checksum: word still written, core held
    do_reset(1'b0);
    push(32'h0, 32'h44332211);
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h00);
    @(negedge clk);
    chk("cs_bad_flags", {29'd0, core_hold, load_done, err}, 32'b101);
`endif
    repeat (2) @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
